// File: rtl/task_graph_streamer.sv
// task_graph_streamer: holds one task-graph adjacency matrix and streams
// it row-major, one entry per hold window, to the task mapper.
module task_graph_streamer #(
  parameter int NUM_V    = 4,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = $clog2(NUM_V),
  parameter int HOLD_CYC = 2,
  parameter int CNT_W    = $clog2(NUM_V*NUM_V+1)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 wr_en,
  input  logic [2*IDX_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 start,
  input  logic                 mapper_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 task_valid,
  output logic [DATA_W-1:0]    task_array,
  output logic                 root_task,
  output logic [IDX_W-1:0]     row,
  output logic [IDX_W-1:0]     col,
  output logic [CNT_W-1:0]     edge_count
);

  localparam int N_ENT = NUM_V * NUM_V;
  localparam int AW    = 2 * IDX_W;
  localparam int HC_W  = $clog2(HOLD_CYC + 1);

  localparam logic [AW:0]      N_ENT_W = (AW+1)'(N_ENT);
  localparam logic [HC_W-1:0]  HOLD_M1 = HC_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_ENT);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_V - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mem [N_ENT];
  logic [HC_W-1:0]   hold_cnt;
  logic              armed;

  logic              advance;
  logic              last;
  logic              load;
  logic              wr_ok;
  logic [IDX_W-1:0]  row_nx;
  logic [IDX_W-1:0]  col_nx;
  logic [AW-1:0]     rd_idx;
  logic [DATA_W-1:0] rd_data;

  assign last    = (row == IDX_MAX) && (col == IDX_MAX);
  assign advance = (state == PRESENT) && (hold_cnt >= HOLD_M1)
                   && mapper_ready;
  assign load    = (state == FETCH) || (advance && !last);
  assign wr_ok   = wr_en && ((state == IDLE) || (state == DONE))
                   && ({1'b0, wr_addr} < N_ENT_W);
  assign rd_data = mem[rd_idx];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = FETCH;
      FETCH:   state_n = PRESENT;
      PRESENT: if (advance && last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    busy       = 1'b0;
    task_valid = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE:    ;
      FETCH:   busy = 1'b1;
      PRESENT: begin
        busy       = 1'b1;
        task_valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Row-major successor of the current entry; FETCH restarts at (0,0)
  always_comb begin
    row_nx = row;
    col_nx = col + 1'b1;
    if (col == IDX_MAX) begin
      col_nx = '0;
      row_nx = row + 1'b1;
    end
    if (state == FETCH) begin
      row_nx = '0;
      col_nx = '0;
    end
    rd_idx = AW'(row_nx) * AW'(NUM_V) + AW'(col_nx);
  end

  // Matrix storage, writable only when no scan is running
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < N_ENT; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Presented entry, hold timer, edge counter and root detection
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      task_array <= '0;
      root_task  <= 1'b0;
      row        <= '0;
      col        <= '0;
      edge_count <= '0;
      hold_cnt   <= '0;
      armed      <= 1'b0;
    end else begin
      root_task <= 1'b0;
      if ((state == IDLE) && start) begin
        row        <= '0;
        col        <= '0;
        edge_count <= '0;
        armed      <= 1'b1;
      end
      if (load) begin
        row        <= row_nx;
        col        <= col_nx;
        task_array <= rd_data;
        hold_cnt   <= '0;
        if (rd_data != '0) begin
          if (edge_count != CNT_MAX) edge_count <= edge_count + 1'b1;
          if (armed) begin
            root_task <= 1'b1;
            armed     <= 1'b0;
          end
        end
      end else if ((state == PRESENT) && (hold_cnt < HOLD_M1)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (advance && last) task_array <= '0;
    end
  end

endmodule

// File: tb/tb_task_graph_streamer.sv
// tb_task_graph_streamer: scenario tasks checked cycle by cycle against
// an interval-based model of the scan timeline.
module tb_task_graph_streamer;

  localparam int NV   = 4;
  localparam int NE   = NV * NV;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic        mapper_ready = 1'b1;
  logic        busy, done, task_valid, root_task;
  logic [31:0] task_array;
  logic [1:0]  row, col;
  logic [4:0]  edge_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m [NE];
  bit          rdy_pat [512];

  task_graph_streamer #(
    .NUM_V(NV), .DATA_W(32), .HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .mapper_ready(mapper_ready),
    .busy(busy), .done(done), .task_valid(task_valid),
    .task_array(task_array), .root_task(root_task), .row(row),
    .col(col), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  function automatic bit rdy_at(input int c);
    return (c < 512) ? rdy_pat[c] : 1'b1;
  endfunction

  function automatic logic [44:0] pack_obs();
    return {busy, done, task_valid, root_task, row, col, edge_count,
            task_array};
  endfunction

  function automatic logic [44:0] mk(input bit b, input bit d,
                                     input bit v, input bit r,
                                     input int rr, input int cc,
                                     input int ec, input logic [31:0] ta);
    return {b, d, v, r, 2'(rr), 2'(cc), 5'(ec), ta};
  endfunction

  task automatic write_word(input int a, input logic [31:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    m[a] = d;
  endtask

  task automatic push_m();
    for (int i = 0; i < NE; i++) write_word(i, m[i]);
  endtask

  task automatic set_directed();
    for (int i = 0; i < NE; i++) m[i] = '0;
    m[1] = 5; m[3] = 7; m[4] = 5; m[6] = 6; m[9] = 6; m[12] = 7;
  endtask

  task automatic rdy_all();
    for (int i = 0; i < 512; i++) rdy_pat[i] = 1'b1;
  endtask

  task automatic run_scan(input string name, input int rst_at,
                          input bit inject, input bit keep);
    int s [NE+1];
    int cum [NE];
    int first_nz, nz, c, k, dc, t;
    logic [44:0] exp_v, obs;
    first_nz = -1;
    nz = 0;
    for (int i = 0; i < NE; i++) begin
      if (m[i] != 0) begin
        nz++;
        if (first_nz < 0) first_nz = i;
      end
      cum[i] = nz;
    end
    s[0] = 2;
    for (int i = 0; i < NE; i++) begin
      c = s[i] + HOLD - 1;
      while (!rdy_at(c)) c++;
      s[i+1] = c + 1;
    end
    dc = s[NE];

    @(posedge clk); #1;
    start = 1'b1;
    wr_en = 1'b0;
    mapper_ready = rdy_at(0);
    @(negedge clk);
    checks++;
    if ({busy, done, task_valid} !== 3'b000) begin
      errors++;
      $display("FAIL %s idle: busy,done,valid=%b want 000",
               name, {busy, done, task_valid});
    end

    for (int n = 1; n <= dc + 1; n++) begin
      @(posedge clk); #1;
      start = keep;
      mapper_ready = rdy_at(n);
      wr_en = 1'b0;
      if (inject && n == 8) begin
        wr_en = 1'b1;
        wr_addr = 4'd5;
        wr_data = 32'd9;
        start = 1'b1;
      end
      if (n == rst_at) rst_b = 1'b0;
      @(negedge clk);
      if (n == 1) begin
        exp_v = mk(1, 0, 0, 0, 0, 0, 0, 0);
      end else if (n < dc) begin
        k = 0;
        for (int i = 0; i < NE; i++) if (s[i] <= n) k = i;
        exp_v = mk(1, 0, 1, (n == s[k]) && (k == first_nz),
                   k / NV, k % NV, cum[k], m[k]);
      end else if (n == dc) begin
        exp_v = mk(0, 1, 0, 0, NV-1, NV-1, nz, 0);
      end else begin
        exp_v = mk(0, 0, 0, 0, NV-1, NV-1, nz, 0);
      end
      obs = pack_obs();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: {busy,done,valid,root,row,col,cnt,data} got %h want %h",
                 name, n, obs, exp_v);
      end
      if (n == rst_at) break;
    end

    if (rst_at > 0) begin
      @(posedge clk); #1;
      rst_b = 1'b1;
      start = 1'b0;
      @(negedge clk);
      obs = pack_obs();
      checks++;
      if (obs !== 45'd0) begin
        errors++;
        $display("FAIL %s after_reset: outputs got %h want 0", name, obs);
      end
      for (int i = 0; i < NE; i++) m[i] = '0;
    end

    if (keep) begin
      @(posedge clk); #1;
      start = 1'b0;
      mapper_ready = 1'b1;
      @(negedge clk);
      obs = pack_obs();
      checks++;
      if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL %s restart_fetch: got %h want %h",
                 name, obs, mk(1, 0, 0, 0, 0, 0, 0, 0));
      end
      t = 0;
      while (t < 200 && done !== 1'b1) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL %s restart_done: done got %b want 1 within 200",
                 name, done);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [44:0] obs;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    obs = pack_obs();
    checks++;
    if (obs !== 45'd0) begin
      errors++;
      $display("FAIL reset: outputs got %h want 0", obs);
    end
    for (int i = 0; i < NE; i++) m[i] = '0;
  endtask

  task automatic test_directed();
    set_directed();
    push_m();
    rdy_all();
    run_scan("directed", -1, 0, 0);
  endtask

  task automatic test_stall();
    rdy_all();
    for (int i = 6; i <= 9; i++) rdy_pat[i] = 1'b0;
    run_scan("stall", -1, 0, 0);
    rdy_all();
  endtask

  task automatic test_zero();
    for (int i = 0; i < NE; i++) m[i] = '0;
    push_m();
    run_scan("zero", -1, 0, 0);
  endtask

  task automatic test_mid_reset();
    set_directed();
    push_m();
    run_scan("mid_reset", 10, 0, 0);
    run_scan("cleared", -1, 0, 0);
    set_directed();
    push_m();
    run_scan("reload", -1, 0, 0);
  endtask

  task automatic test_ignore();
    run_scan("ignore_busy", -1, 1, 0);
  endtask

  task automatic test_write_after_done();
    write_word(3, 32'h0000_1234);
    run_scan("rewrite", -1, 0, 0);
  endtask

  task automatic test_last_only();
    for (int i = 0; i < NE; i++) m[i] = '0;
    m[15] = 1;
    push_m();
    run_scan("last_only", -1, 0, 0);
  endtask

  task automatic test_back_to_back();
    set_directed();
    push_m();
    run_scan("back_to_back", -1, 0, 1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NE; i++)
        m[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
      push_m();
      for (int i = 0; i < 512; i++)
        rdy_pat[i] = ($urandom_range(0, 3) != 0);
      run_scan($sformatf("random%0d", it), -1, 0, 0);
    end
    rdy_all();
  endtask

  initial begin
    rdy_all();
    test_reset();
    test_directed();
    test_stall();
    test_zero();
    test_mid_reset();
    test_ignore();
    test_write_after_done();
    test_last_only();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
